// File: rtl/noc_pkg.sv
// Shared definitions for the NoC source-side packetizer:
// header field layout, packetizer FSM states and the header formatter.
// Header layout (MSB first): dst_x | dst_y | src_x | src_y | len | seq | zero fill.
package noc_pkg;

   // Packetizer control states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

   // Sequence field width is fixed regardless of flit geometry
   localparam int SEQ_W = 8;

   // Widest flit the shared formatter supports
   localparam int MAX_FLIT_W = 128;
   typedef logic [MAX_FLIT_W-1:0] hdr_bus_t;

   // Field offsets for the default geometry (32-bit flit, 2-bit coords, 8-bit length)
   localparam int DEF_FLIT_W  = 32;
   localparam int DEF_COORD_W = 2;
   localparam int DEF_LEN_W   = 8;
   localparam int DST_X_LSB   = DEF_FLIT_W - DEF_COORD_W;
   localparam int DST_Y_LSB   = DEF_FLIT_W - 2*DEF_COORD_W;
   localparam int SRC_X_LSB   = DEF_FLIT_W - 3*DEF_COORD_W;
   localparam int SRC_Y_LSB   = DEF_FLIT_W - 4*DEF_COORD_W;
   localparam int LEN_LSB     = SRC_Y_LSB - DEF_LEN_W;
   localparam int SEQ_LSB     = LEN_LSB - SEQ_W;

   // Field offsets for an arbitrary geometry
   function automatic int dst_x_lsb(input int flit_w, input int coord_w);
      return flit_w - coord_w;
   endfunction

   function automatic int dst_y_lsb(input int flit_w, input int coord_w);
      return flit_w - 2*coord_w;
   endfunction

   function automatic int src_x_lsb(input int flit_w, input int coord_w);
      return flit_w - 3*coord_w;
   endfunction

   function automatic int src_y_lsb(input int flit_w, input int coord_w);
      return flit_w - 4*coord_w;
   endfunction

   function automatic int len_lsb(input int flit_w, input int coord_w, input int len_w);
      return flit_w - 4*coord_w - len_w;
   endfunction

   function automatic int seq_lsb(input int flit_w, input int coord_w, input int len_w);
      return flit_w - 4*coord_w - len_w - SEQ_W;
   endfunction

   // Build a header flit right-aligned in a MAX_FLIT_W bus; callers keep the low flit_w bits.
   // Each field is masked to its width so out-of-range values cannot spill into neighbours.
   function automatic hdr_bus_t build_hdr(
      input int              flit_w,
      input int              coord_w,
      input int              len_w,
      input logic [31:0]     dst_x,
      input logic [31:0]     dst_y,
      input logic [31:0]     src_x,
      input logic [31:0]     src_y,
      input logic [31:0]     len,
      input logic [SEQ_W-1:0] seq
   );
      hdr_bus_t h;
      hdr_bus_t cmask;
      hdr_bus_t lmask;
      cmask = (hdr_bus_t'(1) << coord_w) - hdr_bus_t'(1);
      lmask = (hdr_bus_t'(1) << len_w) - hdr_bus_t'(1);
      h = '0;
      h = h | ((hdr_bus_t'(dst_x) & cmask) << dst_x_lsb(flit_w, coord_w));
      h = h | ((hdr_bus_t'(dst_y) & cmask) << dst_y_lsb(flit_w, coord_w));
      h = h | ((hdr_bus_t'(src_x) & cmask) << src_x_lsb(flit_w, coord_w));
      h = h | ((hdr_bus_t'(src_y) & cmask) << src_y_lsb(flit_w, coord_w));
      h = h | ((hdr_bus_t'(len)   & lmask) << len_lsb(flit_w, coord_w, len_w));
      h = h | (hdr_bus_t'(seq) << seq_lsb(flit_w, coord_w, len_w));
      return h;
   endfunction

endpackage

// File: rtl/noc_pkt_hdr_build.sv
// Combinational header formatter. Shared between the packetizer and the
// depacketizer-side checker so both agree on the header layout.
module noc_pkt_hdr_build
   import noc_pkg::*;
#(
   parameter int FLIT_W  = 32,
   parameter int COORD_W = 2,
   parameter int LEN_W   = 8,
   parameter int SRC_X   = 0,
   parameter int SRC_Y   = 0
) (
   input  logic [COORD_W-1:0] i_dst_x,
   input  logic [COORD_W-1:0] i_dst_y,
   input  logic [LEN_W-1:0]   i_len,
   input  logic [SEQ_W-1:0]   i_seq,
   output logic [FLIT_W-1:0]  o_hdr
);

   // Reject geometries where the header fields cannot fit in one flit
   if ((FLIT_W < 4*COORD_W + LEN_W + SEQ_W) || (FLIT_W > MAX_FLIT_W)) begin : g_bad_geom
      $error("noc_pkt_hdr_build: FLIT_W=%0d cannot hold the header fields", FLIT_W);
   end

   assign o_hdr = FLIT_W'(build_hdr(FLIT_W, COORD_W, LEN_W,
                                    32'(i_dst_x), 32'(i_dst_y),
                                    32'(SRC_X), 32'(SRC_Y),
                                    32'(i_len), i_seq));

endmodule

// File: rtl/noc_packetizer.sv
// Source-side network interface: turns a descriptor plus payload stream into a
// wormhole packet (header flit, then msg_len body flits) for one router port.
// A single output register drives all sender_* signals; a new flit may load
// whenever that register is empty or being drained this cycle.
// Optional build macro: NOC_PKT_SEQ_EN adds an 8-bit per-source sequence
// number in the header (wraps 255->0); without it the seq field is zero.
module noc_packetizer
   import noc_pkg::*;
#(
   parameter int FLIT_W  = 32,
   parameter int COORD_W = 2,
   parameter int LEN_W   = 8,
   parameter int SRC_X   = 0,
   parameter int SRC_Y   = 0
) (
   input  logic               noc_clk,
   input  logic               noc_rst,
   input  logic               msg_valid,
   output logic               msg_ready,
   input  logic [COORD_W-1:0] msg_dst_x,
   input  logic [COORD_W-1:0] msg_dst_y,
   input  logic [LEN_W-1:0]   msg_len,
   input  logic               payload_valid,
   output logic               payload_ready,
   input  logic [FLIT_W-1:0]  payload_data,
   output logic               sender_valid,
   input  logic               sender_ready,
   output logic [FLIT_W-1:0]  sender_flit,
   input  logic               sender_VCready,
   output logic               sender_is_header,
   output logic               sender_is_tail
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LEN_W-1:0]    r_rem;
   logic                r_valid;
   logic [FLIT_W-1:0]   r_flit;
   logic                r_is_hdr;
   logic                r_is_tail;

   logic                w_load_ok;
   logic                w_msg_rdy;
   logic                w_pay_rdy;
   logic                w_ld_hdr;
   logic                w_ld_body;
   logic [FLIT_W-1:0]   w_hdr;
   logic [SEQ_W-1:0]    w_seq;

   // Output register is free when empty or when its flit leaves this cycle
   assign w_load_ok = !r_valid || sender_ready;

`ifdef NOC_PKT_SEQ_EN
   logic [SEQ_W-1:0]    r_seq;

   // Per-source sequence number, advanced on every accepted descriptor
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         r_seq <= '0;
      end else if (w_ld_hdr) begin
         r_seq <= r_seq + SEQ_W'(1);
      end
   end

   assign w_seq = r_seq;
`else
   assign w_seq = '0;
`endif

   noc_pkt_hdr_build #(
      .FLIT_W  (FLIT_W),
      .COORD_W (COORD_W),
      .LEN_W   (LEN_W),
      .SRC_X   (SRC_X),
      .SRC_Y   (SRC_Y)
   ) u_hdr (
      .i_dst_x (msg_dst_x),
      .i_dst_y (msg_dst_y),
      .i_len   (msg_len),
      .i_seq   (w_seq),
      .o_hdr   (w_hdr)
   );

   // Next-state and handshake decode; VC availability only gates packet start
   always_comb begin
      w_state_nxt = r_state;
      w_msg_rdy   = 1'b0;
      w_pay_rdy   = 1'b0;
      w_ld_hdr    = 1'b0;
      w_ld_body   = 1'b0;
      case (r_state)
         IDLE: begin
            w_msg_rdy = sender_VCready && w_load_ok;
            if (msg_valid && w_msg_rdy) begin
               w_ld_hdr = 1'b1;
               if (msg_len != '0) begin
                  w_state_nxt = BODY;
               end
            end
         end
         BODY: begin
            w_pay_rdy = w_load_ok;
            if (payload_valid && w_pay_rdy) begin
               w_ld_body = 1'b1;
               if (r_rem == LEN_W'(1)) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Remaining body-flit counter; full LEN_W range so the maximum length never wraps
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         r_rem <= '0;
      end else if (w_ld_hdr) begin
         r_rem <= msg_len;
      end else if (w_ld_body) begin
         r_rem <= r_rem - LEN_W'(1);
      end
   end

   // Output flit register: load header or body, drain when accepted, hold under backpressure
   always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
         r_valid   <= 1'b0;
         r_flit    <= '0;
         r_is_hdr  <= 1'b0;
         r_is_tail <= 1'b0;
      end else if (w_ld_hdr) begin
         r_valid   <= 1'b1;
         r_flit    <= w_hdr;
         r_is_hdr  <= 1'b1;
         r_is_tail <= (msg_len == '0);
      end else if (w_ld_body) begin
         r_valid   <= 1'b1;
         r_flit    <= payload_data;
         r_is_hdr  <= 1'b0;
         r_is_tail <= (r_rem == LEN_W'(1));
      end else if (sender_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign msg_ready        = w_msg_rdy;
   assign payload_ready    = w_pay_rdy;
   assign sender_valid     = r_valid;
   assign sender_flit      = r_flit;
   assign sender_is_header = r_is_hdr;
   assign sender_is_tail   = r_is_tail;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: a per-cycle vector table plus
// hand-written sequences for backpressure, reset and maximum length.
module tb_noc_packetizer;

   localparam int FLIT_W  = 32;
   localparam int COORD_W = 2;
   localparam int LEN_W   = 8;

   logic               noc_clk = 1'b0;
   logic               noc_rst;
   logic               msg_valid;
   logic               msg_ready;
   logic [COORD_W-1:0] msg_dst_x;
   logic [COORD_W-1:0] msg_dst_y;
   logic [LEN_W-1:0]   msg_len;
   logic               payload_valid;
   logic               payload_ready;
   logic [FLIT_W-1:0]  payload_data;
   logic               sender_valid;
   logic               sender_ready;
   logic [FLIT_W-1:0]  sender_flit;
   logic               sender_VCready;
   logic               sender_is_header;
   logic               sender_is_tail;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        mv;
      logic [1:0]  dx;
      logic [1:0]  dy;
      logic [7:0]  len;
      logic        pv;
      logic [31:0] pd;
      logic        sr;
      logic        vc;
      logic        e_mr;
      logic        e_pr;
      logic        e_v;
      logic [31:0] e_flit;
      logic        e_h;
      logic        e_t;
   } vec_t;

   vec_t tbl [17];

   noc_packetizer #(
      .FLIT_W  (FLIT_W),
      .COORD_W (COORD_W),
      .LEN_W   (LEN_W),
      .SRC_X   (0),
      .SRC_Y   (0)
   ) dut (
      .noc_clk          (noc_clk),
      .noc_rst          (noc_rst),
      .msg_valid        (msg_valid),
      .msg_ready        (msg_ready),
      .msg_dst_x        (msg_dst_x),
      .msg_dst_y        (msg_dst_y),
      .msg_len          (msg_len),
      .payload_valid    (payload_valid),
      .payload_ready    (payload_ready),
      .payload_data     (payload_data),
      .sender_valid     (sender_valid),
      .sender_ready     (sender_ready),
      .sender_flit      (sender_flit),
      .sender_VCready   (sender_VCready),
      .sender_is_header (sender_is_header),
      .sender_is_tail   (sender_is_tail)
   );

   always #5 noc_clk = ~noc_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   // Expected seq field for the n-th header since reset
   function automatic logic [7:0] seq_of(input int n);
      logic [7:0] s;
      s = 8'(n);
`ifndef NOC_PKT_SEQ_EN
      s = 8'h00;
`endif
      return s;
   endfunction

   // Expected header: dst_x[31:30] dst_y[29:28] src_x/src_y=0 len[23:16] seq[15:8]
   function automatic logic [31:0] hdr(input int dx, input int dy, input int len, input int n);
      return {2'(dx), 2'(dy), 4'b0000, 8'(len), seq_of(n), 8'h00};
   endfunction

   function automatic vec_t mk(input int mv, input int dx, input int dy, input int len,
                               input int pv, input logic [31:0] pd, input int sr, input int vc,
                               input int e_mr, input int e_pr, input int e_v,
                               input logic [31:0] e_flit, input int e_h, input int e_t);
      vec_t v;
      v.mv = 1'(mv);   v.dx = 2'(dx);   v.dy = 2'(dy);   v.len = 8'(len);
      v.pv = 1'(pv);   v.pd = pd;       v.sr = 1'(sr);   v.vc = 1'(vc);
      v.e_mr = 1'(e_mr); v.e_pr = 1'(e_pr); v.e_v = 1'(e_v);
      v.e_flit = e_flit; v.e_h = 1'(e_h); v.e_t = 1'(e_t);
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, check readies mid-cycle, check the output register after the edge
   task automatic apply(input vec_t v, input string tag);
      msg_valid      = v.mv;
      msg_dst_x      = v.dx;
      msg_dst_y      = v.dy;
      msg_len        = v.len;
      payload_valid  = v.pv;
      payload_data   = v.pd;
      sender_ready   = v.sr;
      sender_VCready = v.vc;
      @(negedge noc_clk);
      chk1({tag, ".msg_ready"}, msg_ready, v.e_mr);
      chk1({tag, ".payload_ready"}, payload_ready, v.e_pr);
      @(posedge noc_clk);
      #1;
      chk1({tag, ".sender_valid"}, sender_valid, v.e_v);
      if (v.e_v) begin
         chk32({tag, ".flit"}, sender_flit, v.e_flit);
         chk1({tag, ".is_header"}, sender_is_header, v.e_h);
         chk1({tag, ".is_tail"}, sender_is_tail, v.e_t);
      end
   endtask

   initial begin
      //            mv dx dy len pv pd        sr vc  mr pr v  flit              h  t
      // header-only packet
      tbl[0]  = mk(1, 1, 1, 0,  0, 32'h0,   1, 1,  1, 0, 1, hdr(1,1,0,0),    1, 1);
      tbl[1]  = mk(0, 0, 0, 0,  0, 32'h0,   1, 1,  1, 0, 0, 32'h0,           0, 0);
      // three body flits
      tbl[2]  = mk(1, 2, 3, 3,  0, 32'h0,   1, 1,  1, 0, 1, hdr(2,3,3,1),    1, 0);
      tbl[3]  = mk(0, 0, 0, 0,  1, 32'hA1,  1, 1,  0, 1, 1, 32'hA1,          0, 0);
      tbl[4]  = mk(0, 0, 0, 0,  1, 32'hA2,  1, 1,  0, 1, 1, 32'hA2,          0, 0);
      tbl[5]  = mk(0, 0, 0, 0,  1, 32'hA3,  1, 1,  0, 1, 1, 32'hA3,          0, 1);
      tbl[6]  = mk(0, 0, 0, 0,  0, 32'h0,   1, 1,  1, 0, 0, 32'h0,           0, 0);
      // VC gating: blocked start, then body continues with VCready low
      tbl[7]  = mk(1, 1, 0, 2,  0, 32'h0,   1, 0,  0, 0, 0, 32'h0,           0, 0);
      tbl[8]  = mk(1, 1, 0, 2,  0, 32'h0,   1, 1,  1, 0, 1, hdr(1,0,2,2),    1, 0);
      tbl[9]  = mk(0, 0, 0, 0,  1, 32'hB1,  1, 0,  0, 1, 1, 32'hB1,          0, 0);
      tbl[10] = mk(0, 0, 0, 0,  1, 32'hB2,  1, 0,  0, 1, 1, 32'hB2,          0, 1);
      tbl[11] = mk(0, 0, 0, 0,  0, 32'h0,   1, 1,  1, 0, 0, 32'h0,           0, 0);
      // back-to-back single-body packets, descriptor and payload both offered every cycle
      tbl[12] = mk(1, 3, 2, 1,  1, 32'hC1,  1, 1,  1, 0, 1, hdr(3,2,1,3),    1, 0);
      tbl[13] = mk(1, 3, 2, 1,  1, 32'hC1,  1, 1,  0, 1, 1, 32'hC1,          0, 1);
      tbl[14] = mk(1, 1, 2, 1,  1, 32'hC2,  1, 1,  1, 0, 1, hdr(1,2,1,4),    1, 0);
      tbl[15] = mk(0, 0, 0, 0,  1, 32'hC2,  1, 1,  0, 1, 1, 32'hC2,          0, 1);
      tbl[16] = mk(0, 0, 0, 0,  0, 32'h0,   1, 1,  1, 0, 0, 32'h0,           0, 0);

      // reset state
      noc_rst        = 1'b1;
      msg_valid      = 1'b0;
      msg_dst_x      = '0;
      msg_dst_y      = '0;
      msg_len        = '0;
      payload_valid  = 1'b0;
      payload_data   = '0;
      sender_ready   = 1'b1;
      sender_VCready = 1'b0;
      repeat (2) @(posedge noc_clk);
      @(negedge noc_clk);
      chk1("reset.sender_valid", sender_valid, 1'b0);
      chk32("reset.flit", sender_flit, 32'h0);
      chk1("reset.is_header", sender_is_header, 1'b0);
      chk1("reset.is_tail", sender_is_tail, 1'b0);
      chk1("reset.msg_ready", msg_ready, 1'b0);
      chk1("reset.payload_ready", payload_ready, 1'b0);
      @(posedge noc_clk);
      #1;
      noc_rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // backpressure: second body flit held for five cycles while D3 waits
      apply(mk(1, 0, 1, 3, 0, 32'h0,  1, 1, 1, 0, 1, hdr(0,1,3,5), 1, 0), "bp.hdr");
      apply(mk(0, 0, 0, 0, 1, 32'hD1, 1, 1, 0, 1, 1, 32'hD1,       0, 0), "bp.d1");
      apply(mk(0, 0, 0, 0, 1, 32'hD2, 1, 1, 0, 1, 1, 32'hD2,       0, 0), "bp.d2");
      for (int i = 0; i < 5; i++) begin
         apply(mk(0, 0, 0, 0, 1, 32'hD3, 0, 1, 0, 0, 1, 32'hD2, 0, 0), $sformatf("bp.hold%0d", i));
      end
      apply(mk(0, 0, 0, 0, 1, 32'hD3, 1, 1, 0, 1, 1, 32'hD3,       0, 1), "bp.d3");
      apply(mk(0, 0, 0, 0, 0, 32'h0,  1, 1, 1, 0, 0, 32'h0,        0, 0), "bp.idle");

      // reset in the middle of a four-body packet
      apply(mk(1, 1, 1, 4, 0, 32'h0, 1, 1, 1, 0, 1, hdr(1,1,4,6), 1, 0), "rst.hdr");
      msg_valid     = 1'b0;
      payload_valid = 1'b1;
      payload_data  = 32'hE1;
      #2;
      noc_rst = 1'b1;
      #1;
      chk1("rst.async_valid", sender_valid, 1'b0);
      chk1("rst.async_header", sender_is_header, 1'b0);
      @(posedge noc_clk);
      #1;
      noc_rst       = 1'b0;
      payload_valid = 1'b0;
      apply(mk(1, 2, 2, 0, 0, 32'h0, 1, 1, 1, 0, 1, hdr(2,2,0,0), 1, 1), "rst.new");
      apply(mk(0, 0, 0, 0, 0, 32'h0, 1, 1, 1, 0, 0, 32'h0,        0, 0), "rst.idle");

      // maximum length: 255 body flits, tail only on the last
      apply(mk(1, 0, 0, 255, 0, 32'h0, 1, 1, 1, 0, 1, hdr(0,0,255,1), 1, 0), "max.hdr");
      for (int i = 1; i <= 255; i++) begin
         apply(mk(0, 0, 0, 0, 1, 32'(i), 1, 1, 0, 1, 1, 32'(i), 0, (i == 255) ? 1 : 0),
               $sformatf("max.b%0d", i));
      end
      apply(mk(0, 0, 0, 0, 0, 32'h0, 1, 1, 1, 0, 0, 32'h0, 0, 0), "max.idle");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Source-side network interface stage that feeds one router's local injection (sender) port.
- Accepts a message descriptor (destination, body length) plus a payload word stream.
- Emits a wormhole packet to the router: one header flit, then body flits, with is_header/is_tail framing.
- Respects valid/ready per flit; sender_VCready gates packet start only.

Parameters:
- FLIT_W, 32, flit width in bits; must satisfy FLIT_W >= 4*COORD_W+LEN_W+8.
- COORD_W, 2, width of each X/Y mesh coordinate.
- LEN_W, 8, width of the body-flit count field.
- SRC_X, 0, this node's X coordinate, placed in the header.
- SRC_Y, 0, this node's Y coordinate, placed in the header.

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  asynchronous, active-high reset.
- msg_valid  in  1  descriptor valid.
- msg_ready  out  1  descriptor accepted when msg_valid && msg_ready.
- msg_dst_x  in  COORD_W  destination X.
- msg_dst_y  in  COORD_W  destination Y.
- msg_len  in  LEN_W  number of body flits (0 = header-only packet).
- payload_valid  in  1  payload word valid.
- payload_ready  out  1  payload word accepted when payload_valid && payload_ready.
- payload_data  in  FLIT_W  body flit content.
- sender_valid  out  1  flit valid to router.
- sender_ready  in  1  router accepts flit this cycle.
- sender_flit  out  FLIT_W  flit.
- sender_VCready  in  1  router has a free VC for a new packet.
- sender_is_header  out  1  flit is the header.
- sender_is_tail  out  1  flit is the last flit of the packet.

Behaviour:
- Single output register (o_valid, flit, is_header, is_tail); it drives all sender_* outputs.
- Define load_ok = !o_valid || sender_ready.
- Reset: all outputs 0, state IDLE, counter 0, sequence 0. Reset mid-packet drops the partial packet; the router is reset in the same domain.
- State IDLE:
  - msg_ready = sender_VCready && load_ok; payload_ready = 0.
  - On accept, load the header: [FLIT_W-1 -: COORD_W] dst_x, then dst_y, SRC_X, SRC_Y, msg_len (LEN_W), seq (8), remaining bits 0.
  - Set is_header=1 and is_tail=(msg_len==0); rem <= msg_len.
  - Next state is BODY if msg_len != 0, otherwise stay in IDLE.
- State BODY:
  - msg_ready = 0; payload_ready = load_ok.
  - On accept, load payload_data with is_header=0 and is_tail=(rem==1); rem <= rem-1.
  - When rem==1 is accepted, next state is IDLE.
- If nothing loads while sender_ready is high, o_valid goes to 0 next cycle. Under backpressure the flit and its flags are held stable.
- Latency: a descriptor accepted at cycle N gives its header on sender_* at N+1. Payload behaves the same way.
- Throughput: 1 flit/cycle with no bubble between packets. A new header loads in the cycle the previous tail leaves the output register.
- sender_VCready is sampled only at descriptor accept. Deasserting it mid-packet never stalls body flits.
- msg_len = 2^LEN_W-1: counter holds the full range, no wrap.
- Inputs are ignored while their ready is low.

Optional Feature:
- NOC_PKT_SEQ_EN defined: 8-bit per-source sequence number placed in the header seq field. It increments on each descriptor accept and wraps 255->0.
- NOC_PKT_SEQ_EN undefined: seq field is 0 and no counter is built.

Decomposition:
- noc_pkg holds:
  - header field offsets/widths (DST_X_LSB, DST_Y_LSB, SRC_X_LSB, SRC_Y_LSB, LEN_LSB, SEQ_LSB);
  - the state enum {IDLE, BODY};
  - a function to build the header flit.
- One sub-module is natural: noc_pkt_hdr_build, a combinational header formatter reused by the depacketizer-side checker.

Test Plan:
- Header-only packet: dst=(1,1), len=0 with sender_ready=1 -> one flit with is_header=1, is_tail=1, dst_x field=1, len field=0, msg_ready high again next cycle.
- 3-body packet: len=3, payloads 0xA1, 0xA2, 0xA3, sender_ready=1 -> 4 consecutive flits; is_tail only on 0xA3; header len field=3.
- Backpressure: sender_ready=0 for 5 cycles during the 2nd body flit -> flit, is_header and is_tail held stable; payload_ready=0; resumes with no loss or duplication.
- VC gating: sender_VCready=0 with msg_valid=1 -> msg_ready=0, no header. Drop VCready mid-body -> body flits continue.
- Back-to-back: two len=1 messages with ready held high -> H, B(tail), H, B(tail) on 4 consecutive cycles. With NOC_PKT_SEQ_EN defined, seq fields are 0 and 1.
- Reset mid-packet: assert noc_rst after the header of a len=4 packet -> sender_valid=0 immediately; a new descriptor after release starts with a header.
